// File: rtl/string_composer.sv
// Edit buffer for the custom-text path: collects keyboard characters, maps them to
// font codes, and publishes the string to the renderer on a frame boundary after Enter.
module string_composer #(
  parameter int         STRING_LENGTH = 5,
  parameter logic [7:0] SPACE_CODE    = 8'h7F,
  parameter logic [7:0] PAD_CODE      = 8'h7F
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [7:0]                 char_in,
  input  logic                       char_valid,
  input  logic                       frame_start,
  input  logic                       clear,
  output logic [STRING_LENGTH*8-1:0] str,
  output logic [5:0]                 numchar,
  output logic                       ready,
  output logic                       busy,
  output logic                       full,
  output logic [5:0]                 edit_len
);

  typedef enum logic [1:0] {EDIT, WAIT_FRAME, COMMIT} state_t;

  state_t     state, state_next;
  logic [7:0] edit_buf [STRING_LENGTH];
  logic       accept, do_store, do_back, do_enter, do_commit;
  logic [7:0] store_code;

  assign full   = (edit_len == 6'(STRING_LENGTH));
  assign accept = (state == EDIT) && char_valid && !clear;

  // Character classification; storable codes are dropped once the buffer is full
  always_comb begin
    do_store   = 1'b0;
    do_back    = 1'b0;
    do_enter   = 1'b0;
    store_code = PAD_CODE;
    if (char_in >= 8'h61 && char_in <= 8'h7A) begin
      do_store   = accept && !full;
      store_code = char_in - 8'h20;
    end else if (char_in >= 8'h41 && char_in <= 8'h5A) begin
      do_store   = accept && !full;
      store_code = char_in;
    end else if (char_in == 8'h20) begin
      do_store   = accept && !full;
      store_code = SPACE_CODE;
    end else if (char_in == 8'h08) begin
      do_back    = accept && (edit_len != 6'd0);
    end else if (char_in == 8'h0D) begin
      do_enter   = accept;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= EDIT;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    ready      = 1'b0;
    busy       = 1'b0;
    do_commit  = 1'b0;
    case (state)
      EDIT: begin
        if (do_enter) state_next = WAIT_FRAME;
      end
      WAIT_FRAME: begin
        busy = 1'b1;
        if (frame_start) begin
          state_next = COMMIT;
          do_commit  = !clear;
        end
      end
      COMMIT: begin
        busy       = 1'b1;
        ready      = 1'b1;
        state_next = EDIT;
      end
      default: state_next = EDIT;
    endcase
    if (clear) state_next = EDIT;
  end

  // The committed string is loaded on entry to COMMIT so it is already valid while ready is high
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STRING_LENGTH; i++) edit_buf[i] <= PAD_CODE;
      edit_len <= 6'd0;
      str      <= {STRING_LENGTH{PAD_CODE}};
      numchar  <= 6'd0;
    end else begin
      if (clear) begin
        for (int i = 0; i < STRING_LENGTH; i++) edit_buf[i] <= PAD_CODE;
        edit_len <= 6'd0;
      end else if (do_store) begin
        for (int i = 0; i < STRING_LENGTH; i++)
          if (edit_len == 6'(i)) edit_buf[i] <= store_code;
        edit_len <= edit_len + 6'd1;
      end else if (do_back) begin
        for (int i = 0; i < STRING_LENGTH; i++)
          if (edit_len == 6'(i + 1)) edit_buf[i] <= PAD_CODE;
        edit_len <= edit_len - 6'd1;
      end
      if (do_commit) begin
        for (int i = 0; i < STRING_LENGTH; i++)
          str[STRING_LENGTH*8-1-8*i -: 8] <= edit_buf[i];
        numchar <= edit_len;
      end
    end
  end

endmodule

// File: tb/tb_string_composer.sv
// Scoreboard bench for string_composer: expected commits are queued by the stimulus
// thread and checked by a monitor thread whenever ready pulses.
module tb_string_composer;
  localparam int L = 5;
  localparam int W = L * 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [7:0]   char_in = 8'h00;
  logic         char_valid = 1'b0;
  logic         frame_start = 1'b0;
  logic         clear = 1'b0;
  logic [W-1:0] str;
  logic [5:0]   numchar;
  logic         ready, busy, full;
  logic [5:0]   edit_len;

  typedef struct packed {
    logic [W-1:0] s;
    logic [5:0]   n;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   total = 0;
  int   passed = 0;
  int   commits_seen = 0;
  int   start_commits;

  string_composer #(.STRING_LENGTH(L), .SPACE_CODE(8'h7F), .PAD_CODE(8'h7F)) dut (
    .clk(clk), .rst_n(rst_n), .char_in(char_in), .char_valid(char_valid),
    .frame_start(frame_start), .clear(clear), .str(str), .numchar(numchar),
    .ready(ready), .busy(busy), .full(full), .edit_len(edit_len)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    total++;
    if (actual === expected) passed++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [7:0] c);
    char_in    = c;
    char_valid = 1'b1;
    tick();
    char_valid = 1'b0;
  endtask

  task automatic typeText(input string s);
    for (int i = 0; i < s.len(); i++) applyStimulus(s[i]);
  endtask

  task automatic clearBuf();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic pulseFrame();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic waitCommit(input string name);
    int start = commits_seen;
    for (int cyc = 0; cyc < 20 && commits_seen == start; cyc++) tick();
    checkOutput(name, 64'(commits_seen), 64'(start + 1));
  endtask

  task automatic enterAndCommit(input string name, input logic [W-1:0] s, input logic [5:0] n, input int gap);
    applyStimulus(8'h0D);
    checkOutput({name, "_busy_wait"}, 64'(busy), 64'd1);
    repeat (gap) tick();
    checkOutput({name, "_busy_before_frame"}, 64'(busy), 64'd1);
    exp_q.push_back('{s: s, n: n});
    pulseFrame();
    waitCommit({name, "_commit"});
    checkOutput({name, "_busy_after"}, 64'(busy), 64'd0);
  endtask

  initial begin
    fork
      forever begin
        @(negedge clk);
        if (ready === 1'b1) begin
          if (exp_q.size() == 0) begin
            total++;
            $display("[TB] FAIL unexpected_ready: got ready=1 str=%0h numchar=%0d, expected no ready", str, numchar);
          end else begin
            mon_e = exp_q.pop_front();
            checkOutput("commit_str", 64'(str), 64'(mon_e.s));
            checkOutput("commit_numchar", 64'(numchar), 64'(mon_e.n));
          end
          commits_seen++;
        end
      end
    join_none

    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    checkOutput("reset_str", 64'(str), 64'(40'h7F7F7F7F7F));
    checkOutput("reset_numchar", 64'(numchar), 64'd0);
    checkOutput("reset_ready", 64'(ready), 64'd0);
    checkOutput("reset_busy", 64'(busy), 64'd0);
    checkOutput("reset_full", 64'(full), 64'd0);
    checkOutput("reset_edit_len", 64'(edit_len), 64'd0);

    $display("[TB] pAris");
    typeText("pAris");
    checkOutput("paris_len", 64'(edit_len), 64'd5);
    checkOutput("paris_full", 64'(full), 64'd1);
    enterAndCommit("paris", 40'h5041524953, 6'd5, 10);
    clearBuf();

    $display("[TB] ROMEXY overflow");
    typeText("ROME");
    checkOutput("rome_full", 64'(full), 64'd0);
    applyStimulus("X");
    checkOutput("romex_full", 64'(full), 64'd1);
    applyStimulus("Y");
    checkOutput("romexy_len", 64'(edit_len), 64'd5);
    enterAndCommit("romex", 40'h524F4D4558, 6'd5, 2);
    clearBuf();

    $display("[TB] backspace");
    applyStimulus("A");  checkOutput("bs_len1", 64'(edit_len), 64'd1);
    applyStimulus("B");  checkOutput("bs_len2", 64'(edit_len), 64'd2);
    applyStimulus(8'h08); checkOutput("bs_len3", 64'(edit_len), 64'd1);
    applyStimulus(8'h08); checkOutput("bs_len4", 64'(edit_len), 64'd0);
    applyStimulus(8'h08); checkOutput("bs_len5", 64'(edit_len), 64'd0);
    applyStimulus("C");  checkOutput("bs_len6", 64'(edit_len), 64'd1);
    enterAndCommit("bs", 40'h437F7F7F7F, 6'd1, 3);
    clearBuf();

    $display("[TB] space and unsupported code");
    typeText("A B1");
    checkOutput("space_len", 64'(edit_len), 64'd3);
    enterAndCommit("space", 40'h417F427F7F, 6'd3, 1);
    clearBuf();

    $display("[TB] Enter with same-cycle frame_start, empty buffer");
    start_commits = commits_seen;
    char_in = 8'h0D; char_valid = 1'b1; frame_start = 1'b1;
    tick();
    char_valid = 1'b0; frame_start = 1'b0;
    checkOutput("same_busy", 64'(busy), 64'd1);
    applyStimulus("Z");
    checkOutput("wait_drop_len", 64'(edit_len), 64'd0);
    repeat (3) tick();
    checkOutput("same_no_commit", 64'(commits_seen), 64'(start_commits));
    exp_q.push_back('{s: 40'h7F7F7F7F7F, n: 6'd0});
    pulseFrame();
    waitCommit("same_second_frame");

    $display("[TB] LONDON, clear, reset mid-wait");
    typeText("LONDON");
    enterAndCommit("london", 40'h4C4F4E444F, 6'd5, 4);
    start_commits = commits_seen;
    clearBuf();
    checkOutput("clear_len", 64'(edit_len), 64'd0);
    checkOutput("clear_str", 64'(str), 64'(40'h4C4F4E444F));
    checkOutput("clear_numchar", 64'(numchar), 64'd5);
    typeText("AB");
    applyStimulus(8'h0D);
    tick();
    rst_n = 1'b0;
    #1;
    checkOutput("rst_str", 64'(str), 64'(40'h7F7F7F7F7F));
    checkOutput("rst_numchar", 64'(numchar), 64'd0);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_len", 64'(edit_len), 64'd0);
    tick();
    rst_n = 1'b1;
    pulseFrame();
    repeat (3) tick();
    checkOutput("rst_no_commit", 64'(commits_seen), 64'(start_commits));
    checkOutput("rst_ready", 64'(ready), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
